// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared types, constants and helpers for the multi-channel
//                integer clock divider (clk_div_chan / clk_div_multi).
//                Contents:
//                  chan_state_e  - per-channel state {DIS, BYP, RUN}
//                  MIN_DIV_RATIO - smallest ratio that runs the counter
//                  hi_time()     - high-phase length for a given ratio
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    typedef enum logic [1:0] {
        DIS = 2'd0,   // channel disabled, reference clock passed through
        BYP = 2'd1,   // enabled with ratio < 2, reference clock passed through
        RUN = 2'd2    // counter running, output from the divider flop
    } chan_state_e;

    localparam int MIN_DIV_RATIO = 2;

    // High time of one divided period. For odd ratios the extra cycle goes
    // to the high phase: R=5 -> 3 high, 2 low.
    function automatic logic [31:0] hi_time(input logic [31:0] ratio);
        return ratio - (ratio >> 1);
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One channel of the integer clock divider: state machine,
//                period counter, active ratio and pending-ratio register.
//  Ports       : ref_clk_i   - reference clock
//                rst_i       - asynchronous active-high reset
//                en_i        - channel enable (registered before use)
//                ratio_i     - requested ratio
//                upd_i       - strobe capturing ratio_i as pending ratio
//                sync_i      - strobe restarting a running channel at count 0
//                div_clk_o   - divided clock, or ref_clk_i when not running
//                tick_o      - high in the ref cycle a divided period starts
//                upd_pend_o  - a pending ratio has not been applied yet
//                running_o   - channel is in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int RATIO_W   = 8,
    parameter int DEF_RATIO = 2
) (
    input  logic               ref_clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [RATIO_W-1:0] ratio_i,
    input  logic               upd_i,
    input  logic               sync_i,
    output logic               div_clk_o,
    output logic               tick_o,
    output logic               upd_pend_o,
    output logic               running_o
);

    localparam logic [RATIO_W-1:0] c_def_ratio = RATIO_W'(DEF_RATIO);
    localparam logic [RATIO_W-1:0] c_min_ratio = RATIO_W'(MIN_DIV_RATIO);
    localparam logic [RATIO_W-1:0] c_one       = RATIO_W'(1);

    chan_state_e        state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    // The enable is registered once, so a rising enable sampled at edge k
    // is acted on at edge k+1.
    logic               en_q;

    logic [RATIO_W-1:0] w_hi;
    logic               w_last;
    logic               w_restart;
    logic [RATIO_W-1:0] w_r_restart;
    logic [RATIO_W-1:0] w_r_idle;

    assign w_hi   = RATIO_W'(hi_time(32'(ratio_q)));
    assign w_last = (cnt_q == (ratio_q - c_one));

    // Period boundary in RUN: natural wrap or a sync restart.
    assign w_restart = (state_q == RUN) && (w_last || sync_i);

    // At a boundary an update arriving on that very edge takes effect
    // directly; otherwise a previously captured pending ratio is used.
    assign w_r_restart = upd_i      ? ratio_i :
                         pend_vld_q ? pend_q  : ratio_q;

    // Outside RUN the pending ratio is applied on the next edge.
    assign w_r_idle = pend_vld_q ? pend_q : ratio_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ref_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DIS;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            ratio_q    <= c_def_ratio;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            en_q       <= en_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        // Capture a new request; last write wins over an unapplied one.
        if (upd_i) begin
            pend_d     = ratio_i;
            pend_vld_d = 1'b1;
        end

        unique case (state_q)
            DIS, BYP: begin
                ratio_d = w_r_idle;
                if (pend_vld_q && !upd_i) begin
                    pend_vld_d = 1'b0;
                end
                cnt_d = '0;
                if (!en_q) begin
                    state_d = DIS;
                    div_d   = 1'b0;
                end else if (w_r_idle >= c_min_ratio) begin
                    state_d = RUN;
                    div_d   = 1'b1;
                end else begin
                    state_d = BYP;
                    div_d   = 1'b0;
                end
            end

            RUN: begin
                if (w_restart) begin
                    ratio_d    = w_r_restart;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    // A disable or a sub-2 ratio only takes effect here, so
                    // the running period is always completed.
                    if (!en_q) begin
                        state_d = DIS;
                        div_d   = 1'b0;
                    end else if (w_r_restart < c_min_ratio) begin
                        state_d = BYP;
                        div_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        div_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + c_one;
                    div_d = (cnt_d < w_hi);
                end
            end

            default: begin
                state_d = DIS;
                cnt_d   = '0;
                div_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        div_clk_o  = ref_clk_i;
        tick_o     = 1'b0;
        running_o  = 1'b0;
        upd_pend_o = pend_vld_q;
        unique case (state_q)
            RUN: begin
                div_clk_o = div_q;
                tick_o    = (cnt_q == '0);
                running_o = 1'b1;
            end
            BYP: begin
                tick_o = 1'b1;
            end
            default: begin
                tick_o = 1'b0;
            end
        endcase
    end

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : Multi-channel integer clock divider from one reference
//                clock, with glitch-free ratio updates, graceful stop and a
//                global sync strobe.
//  Ports       : I_ref_clk   - reference clock (only clock)
//                I_rst       - asynchronous active-high reset
//                I_clk_en    - per-channel enable
//                I_div_ratio - channel i ratio at [i*RATIO_W +: RATIO_W]
//                I_ratio_upd - per-channel ratio capture strobe
//                I_sync      - restart all running channels at count 0
//                O_div_clk   - divided clocks
//                O_tick      - per-channel period-start tick
//                O_upd_pend  - per-channel pending ratio flag
//                O_running   - per-channel RUN indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int RATIO_W   = 8,
    parameter int DEF_RATIO = 2
) (
    input  logic                    I_ref_clk,
    input  logic                    I_rst,
    input  logic [N_CH-1:0]         I_clk_en,
    input  logic [N_CH*RATIO_W-1:0] I_div_ratio,
    input  logic [N_CH-1:0]         I_ratio_upd,
    input  logic                    I_sync,
    output logic [N_CH-1:0]         O_div_clk,
    output logic [N_CH-1:0]         O_tick,
    output logic [N_CH-1:0]         O_upd_pend,
    output logic [N_CH-1:0]         O_running
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_chan #(
            .RATIO_W   (RATIO_W),
            .DEF_RATIO (DEF_RATIO)
        ) u_chan (
            .ref_clk_i  (I_ref_clk),
            .rst_i      (I_rst),
            .en_i       (I_clk_en[g]),
            .ratio_i    (I_div_ratio[g*RATIO_W +: RATIO_W]),
            .upd_i      (I_ratio_upd[g]),
            .sync_i     (I_sync),
            .div_clk_o  (O_div_clk[g]),
            .tick_o     (O_tick[g]),
            .upd_pend_o (O_upd_pend[g]),
            .running_o  (O_running[g])
        );
    end

endmodule : clk_div_multi
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Self-checking bench for clk_div_multi. Expected per-cycle
//                channel outputs are queued when stimulus is applied and
//                compared when the matching reference cycle is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int N_CH = 4;
    localparam int RW   = 8;
    localparam int DEF  = 2;
    localparam int PASS = 2;   // expected-div code: pass-through of ref clock

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_CH-1:0]      en  = '0;
    logic [N_CH-1:0]      upd = '0;
    logic [N_CH*RW-1:0]   ratio = '0;
    logic                 sync = 1'b0;
    logic [N_CH-1:0]      div_clk, tick, upd_pend, running;

    clk_div_multi #(.N_CH(N_CH), .RATIO_W(RW), .DEF_RATIO(DEF)) dut (
        .I_ref_clk   (clk),
        .I_rst       (rst),
        .I_clk_en    (en),
        .I_div_ratio (ratio),
        .I_ratio_upd (upd),
        .I_sync      (sync),
        .O_div_clk   (div_clk),
        .O_tick      (tick),
        .O_upd_pend  (upd_pend),
        .O_running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    ch;
        int    div;
        bit    tk;
        bit    run;
        bit    pend;
        string tag;
    } exp_t;

    typedef struct {
        int ch;
        int r;
        int n;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(int c, int ch, int dv, bit tk, bit run, bit pend, string tag);
        exp_t e;
        e.cyc = c; e.ch = ch; e.div = dv; e.tk = tk; e.run = run; e.pend = pend; e.tag = tag;
        sb.push_back(e);
    endfunction

    // Running channel at count k0 in cycle c0, for n cycles.
    function automatic void push_run(string tag, int ch, int r, int k0, int c0, int n, bit pend);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (k0 + i) % r;
            push(c0 + i, ch, (k < (r + 1) / 2) ? 1 : 0, (k == 0), 1'b1, pend, tag);
        end
    endfunction

    function automatic void push_pass(string tag, int ch, int c0, int n, bit tk, bit pend);
        for (int i = 0; i < n; i++) push(c0 + i, ch, PASS, tk, 1'b0, pend, tag);
    endfunction

    // One reference cycle; outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                exp_t e;
                string nm;
                e  = sb[i];
                nm = $sformatf("%s ch%0d cyc%0d", e.tag, e.ch, cyc);
                check({nm, " div"},  32'(div_clk[e.ch]),
                      (e.div == PASS) ? 32'(clk) : 32'(e.div));
                check({nm, " tick"}, 32'(tick[e.ch]),     32'(e.tk));
                check({nm, " run"},  32'(running[e.ch]),  32'(e.run));
                check({nm, " pend"}, 32'(upd_pend[e.ch]), 32'(e.pend));
                sb.delete(i);
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; upd = '0; sync = 1'b0; ratio = '0;
        steps(2);
        rst = 1'b0;
    endtask

    // Request ratio r and enable channel ch. After return the next step()
    // is the first cycle of RUN (or BYP for r < 2).
    task automatic start(input int ch, input int r);
        ratio[ch*RW +: RW] = RW'(r);
        upd[ch] = 1'b1;
        en[ch]  = 1'b1;
        push(cyc + 1, ch, PASS, 1'b0, 1'b0, 1'b1, "start");
        step();
        upd[ch] = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{0, 4, 12};
        tbl[1] = '{1, 5, 15};
        tbl[2] = '{2, 3, 9};
        tbl[3] = '{3, 6, 12};
        tbl[4] = '{0, 2, 6};
        tbl[5] = '{1, 1, 4};
        tbl[6] = '{2, 7, 14};

        // Reset state
        do_reset();
        check("reset running", 32'(running),  32'(0));
        check("reset tick",    32'(tick),     32'(0));
        check("reset pend",    32'(upd_pend), 32'(0));
        check("reset div hi",  32'(div_clk),  32'({N_CH{clk}}));

        // Table: single channel from reset, steady-state waveform
        for (int t = 0; t < 7; t++) begin
            do_reset();
            start(tbl[t].ch, tbl[t].r);
            if (tbl[t].r >= 2)
                push_run("tbl", tbl[t].ch, tbl[t].r, 0, cyc + 1, tbl[t].n, 1'b0);
            else
                push_pass("tbl_byp", tbl[t].ch, cyc + 1, tbl[t].n, 1'b1, 1'b0);
            steps(tbl[t].n);
        end

        // Ratio 4 -> 6 requested at count 1: applied at the wrap
        do_reset();
        start(0, 4);
        push_run("upd", 0, 4, 0, cyc + 1, 2, 1'b0);
        steps(2);
        ratio[0*RW +: RW] = 8'd6;
        upd[0] = 1'b1;
        push_run("upd", 0, 4, 2, cyc + 1, 2, 1'b1);
        step();
        upd[0] = 1'b0;
        step();
        push_run("upd", 0, 6, 0, cyc + 1, 12, 1'b0);
        steps(12);

        // Graceful stop: ch2 R=3, enable dropped at count 0
        do_reset();
        start(2, 3);
        push_run("stop", 2, 3, 0, cyc + 1, 1, 1'b0);
        step();
        en[2] = 1'b0;
        push_run("stop", 2, 3, 1, cyc + 1, 2, 1'b0);
        push_pass("stop", 2, cyc + 3, 3, 1'b0, 1'b0);
        steps(5);
        #5;
        check("stop passthru low", 32'(div_clk[2]), 32'(clk));

        // Sync: ch0 R=3 and ch3 R=6 out of phase, then aligned
        do_reset();
        start(0, 3);
        start(3, 6);
        steps(3);
        sync = 1'b1;
        push_run("sync", 0, 3, 0, cyc + 1, 12, 1'b0);
        push_run("sync", 3, 6, 0, cyc + 1, 12, 1'b0);
        step();
        sync = 1'b0;
        steps(11);

        // Update to R=1 while running -> BYP at the wrap
        do_reset();
        start(1, 4);
        push_run("byp", 1, 4, 0, cyc + 1, 1, 1'b0);
        step();
        ratio[1*RW +: RW] = 8'd1;
        upd[1] = 1'b1;
        push_run("byp", 1, 4, 1, cyc + 1, 3, 1'b1);
        step();
        upd[1] = 1'b0;
        steps(2);
        push_pass("byp", 1, cyc + 1, 4, 1'b1, 1'b0);
        steps(4);

        // Asynchronous reset mid-RUN at count 2 with an update pending
        do_reset();
        start(0, 4);
        push_run("rst", 0, 4, 0, cyc + 1, 2, 1'b0);
        steps(2);
        ratio[0*RW +: RW] = 8'd9;
        upd[0] = 1'b1;
        push_run("rst", 0, 4, 2, cyc + 1, 1, 1'b1);
        step();
        upd[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst running", 32'(running),  32'(0));
        check("midrst tick",    32'(tick),     32'(0));
        check("midrst pend",    32'(upd_pend), 32'(0));
        check("midrst div hi",  32'(div_clk),  32'({N_CH{clk}}));
        #3;
        check("midrst div lo",  32'(div_clk),  32'({N_CH{clk}}));
        step();
        rst = 1'b0;
        push_pass("rst_def", 0, cyc + 1, 1, 1'b0, 1'b0);
        push_run("rst_def", 0, DEF, 0, cyc + 2, 6, 1'b0);
        steps(7);

        check("scoreboard leftover", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_clk_div_multi
`default_nettype wire

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, parametrised integer clock divider driven from one reference clock. It is the successor to the team's single-channel divider and generalises it in three ways: parametrised channel count and ratio width, ratio changes that only take effect at a period boundary (glitch-free), and graceful stop. Each channel also provides a cycle-accurate tick for clock-enable style use, and a global sync strobe phase-aligns all channels. It sits in the clock/reset area and feeds peripheral clock enables and divided clocks.

## Interface
- N_CH, 4, number of independent channels
- RATIO_W, 8, ratio and counter width in bits
- DEF_RATIO, 2, active ratio of every channel after reset
- I_ref_clk  in  1  reference clock; the only clock
- I_rst  in  1  reset, asynchronous, active-high
- I_clk_en  in  N_CH  per-channel enable
- I_div_ratio  in  N_CH*RATIO_W  requested ratios; channel i at [i*RATIO_W +: RATIO_W]
- I_ratio_upd  in  N_CH  one-cycle strobe that captures channel i's ratio into its pending register
- I_sync  in  1  one-cycle strobe that restarts all running channels at count 0
- O_div_clk  out  N_CH  divided clock; I_ref_clk in pass-through states
- O_tick  out  N_CH  high for the ref cycle in which a divided period starts
- O_upd_pend  out  N_CH  pending ratio not yet applied
- O_running  out  N_CH  channel is in state RUN

## Operation
- Per-channel state machine with states DIS, BYP and RUN.
- Active ratio R, high time H = R - (R>>1), RATIO_W-bit unsigned arithmetic.
- DIS (I_clk_en=0):
  - O_div_clk = I_ref_clk; O_tick = 0.
- BYP (enabled, R<2):
  - O_div_clk = I_ref_clk; O_tick = 1.
- RUN (enabled, R>=2):
  - Counter cnt counts 0..R-1 and wraps.
  - Registered output: div_q <= (cnt_next < H).
  - O_tick = (cnt==0).
  - Even R gives 50 % duty; odd R is high (R+1)/2 and low (R-1)/2 cycles.
- Entering RUN from DIS or BYP: cnt<=0, div_q<=1 on the same edge.
- Ratio update:
  - I_ratio_upd loads the pending register and sets O_upd_pend.
  - A second update before the pending value is applied overwrites it (last wins).
  - Application point: the RUN wrap edge (cnt==R-1), the I_sync edge, or the next edge when in DIS or BYP.
  - Applying clears O_upd_pend.
  - An update in the same cycle as a wrap applies the new value directly at that edge.
- Disable: I_clk_en falling during RUN completes the current period; DIS is entered at the wrap edge, never mid-period.
- At a wrap edge, with pending ratio applied:
  - en=0: go to DIS.
  - R<2: go to BYP.
  - Otherwise: stay in RUN, cnt<=0, div_q<=1.
- I_sync: every RUN channel gets cnt<=0, div_q<=1 and its pending ratio applied on that edge; channels not in RUN are unaffected.

## Timing
- Reset values (asynchronous, immediate, including mid-operation):
  - State DIS, cnt 0, div_q 0, R = DEF_RATIO, pending cleared.
  - Outputs: O_div_clk = I_ref_clk, O_tick 0, O_upd_pend 0, O_running 0.
- Enable latency: rising I_clk_en sampled at edge k gives O_running=1, O_div_clk=1 and O_tick=1 after edge k+1.
- O_div_clk in RUN comes from a flop; the only combinational path is the pass-through mux.
- O_tick, O_running and O_upd_pend are decoded from registers; none is combinational from inputs.

## Structure
- Package clk_div_pkg:
  - Channel state enum {DIS, BYP, RUN}.
  - Function hi_time(R) = R - (R>>1).
  - Constant MIN_DIV_RATIO = 2.
- Sub-module clk_div_chan: one channel (FSM, counter, pending register). The top level generates N_CH instances and slices I_div_ratio.

## Test plan
- Ch0 R=4, en=1 -> O_div_clk 1,1,0,0 repeating; O_tick every 4th cycle, coincident with the rising edge.
- Ch1 R=5 -> high 3 cycles, low 2 cycles; tick period 5.
- Ch0 running R=4, update to 6 at cnt=1 -> O_upd_pend=1 until wrap; current period stays 4 cycles, then 3 high/3 low; O_upd_pend clears at the wrap.
- Ch2 R=3, I_clk_en dropped at cnt=0 -> period completes (1,1,0), then DIS and pass-through; O_running falls at the wrap edge.
- Ch0 R=3 and ch3 R=6 out of phase, I_sync pulse -> both go high on the next edge with O_tick=1; rising edges coincide every 6 cycles.
- R=1 update -> BYP with O_tick=1 every cycle.
- I_rst mid-RUN with cnt=2 -> all outputs take reset values immediately and R returns to DEF_RATIO.
